// File: rtl/chacha_qr_unit.sv
// ChaCha quarter-round engine: accepts four 32-bit words, applies S0..S3 over 4/UNROLL cycles,
// and presents the result with a valid/ready handshake.
module chacha_qr_unit #(
    parameter int unsigned UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } quad_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic quad_t qr_step(input logic [1:0] s, input quad_t q);
        quad_t r;
        r = q;
        unique case (s)
            2'd0: begin
                r.a = q.a + q.b;
                r.d = rotl(q.d ^ r.a, 16);
            end
            2'd1: begin
                r.c = q.c + q.d;
                r.b = rotl(q.b ^ r.c, 12);
            end
            2'd2: begin
                r.a = q.a + q.b;
                r.d = rotl(q.d ^ r.a, 8);
            end
            default: begin
                r.c = q.c + q.d;
                r.b = rotl(q.b ^ r.c, 7);
            end
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    quad_t       work_q, work_d;
    quad_t       stepped;
    logic        last_group;
    logic        accept;

    always_comb begin
        stepped = work_q;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            stepped = qr_step(step_q + 2'(i), stepped);
        end
    end

    // The group ends on S3 exactly when the counter wraps back to 0.
    assign last_group = (step_q + 2'(UNROLL - 1)) == 2'd3;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign a_out     = work_q.a;
    assign b_out     = work_q.b;
    assign c_out     = work_q.c;
    assign d_out     = work_q.d;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    work_d  = '{a: a_in, b: b_in, c: c_in, d: d_in};
                    step_d  = 2'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                work_d = stepped;
                step_d = step_q + 2'(UNROLL);
                if (last_group) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = '{a: a_in, b: b_in, c: c_in, d: d_in};
                        step_d  = 2'd0;
                        state_d = StCalc;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            work_q  <= work_d;
        end
    end

endmodule

// File: tb/tb_chacha_qr_unit.sv
// Directed bench for chacha_qr_unit: three instances (UNROLL 1, 2, 4) share the same stimulus.
module tb_chacha_qr_unit;

    localparam logic [127:0] RFC_IN   = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    localparam logic [127:0] RFC_OUT  = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    localparam logic [127:0] ONES_IN  = {4{32'hffffffff}};
    localparam logic [127:0] ONES_OUT = {32'hf0000ffd, 32'h88790878, 32'h0110fdef, 32'h010ffdf0};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_in, b_in, c_in, d_in;

    logic [2:0]  in_ready_w;
    logic [2:0]  out_valid_w;
    logic [2:0]  busy_w;
    logic [31:0] a_w [3];
    logic [31:0] b_w [3];
    logic [31:0] c_w [3];
    logic [31:0] d_w [3];

    int vectors;
    int miscompares;

    chacha_qr_unit #(.UNROLL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .a_out(a_w[0]), .b_out(b_w[0]), .c_out(c_w[0]), .d_out(d_w[0]), .busy(busy_w[0])
    );

    chacha_qr_unit #(.UNROLL(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .a_out(a_w[1]), .b_out(b_w[1]), .c_out(c_w[1]), .d_out(d_w[1]), .busy(busy_w[1])
    );

    chacha_qr_unit #(.UNROLL(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid_w[2]), .out_ready(out_ready),
        .a_out(a_w[2]), .b_out(b_w[2]), .c_out(c_w[2]), .d_out(d_w[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ops(input logic [127:0] v);
        {a_in, b_in, c_in, d_in} = v;
    endtask

    // Leaves the bench at the "#1 after posedge" phase with all instances idle.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [127:0] res;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_ops(RFC_IN);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            res = {a_w[k], b_w[k], c_w[k], d_w[k]};
            vectors++;
            if ({in_ready_w[k], out_valid_w[k], busy_w[k]} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_flags inst=%0d got rdy/vld/busy=%b want 100", k,
                         {in_ready_w[k], out_valid_w[k], busy_w[k]});
            end
            vectors++;
            if (res !== 128'd0) begin
                miscompares++;
                $display("FAIL reset_outputs inst=%0d got %h want 0", k, res);
            end
        end
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (busy_w !== 3'b111) begin
            miscompares++;
            $display("FAIL first_edge_accept got busy=%b want 111", busy_w);
        end
    endtask

    task automatic test_rfc_unroll();
        int first [3];
        int want_lat [3];
        logic [127:0] res;
        want_lat = '{4, 2, 1};
        first = '{-1, -1, -1};
        do_reset();
        set_ops(RFC_IN);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_ops(128'd0);
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid_w[k] && first[k] < 0) first[k] = n;
            end
        end
        for (int k = 0; k < 3; k++) begin
            res = {a_w[k], b_w[k], c_w[k], d_w[k]};
            vectors++;
            if (first[k] != want_lat[k]) begin
                miscompares++;
                $display("FAIL rfc_latency inst=%0d got %0d edges want %0d", k, first[k],
                         want_lat[k]);
            end
            vectors++;
            if (res !== RFC_OUT || out_valid_w[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL rfc_result inst=%0d got %h vld=%b want %h vld=1", k, res,
                         out_valid_w[k], RFC_OUT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        do_reset();
        set_ops(RFC_IN);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_ops(ONES_IN);
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0];
            #1;
            res = {a_w[0], b_w[0], c_w[0], d_w[0]};
            vectors++;
            if (res !== RFC_OUT || out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold cycle=%0d got %h vld=%b rdy=%b want %h vld=1 rdy=0",
                         n, res, out_valid_w[0], in_ready_w[0], RFC_OUT);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff_in_ready got %b want 1", in_ready_w[0]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if ({busy_w[0], out_valid_w[0], in_ready_w[0]} !== 3'b001) begin
            miscompares++;
            $display("FAIL handoff_to_idle got busy/vld/rdy=%b want 001",
                     {busy_w[0], out_valid_w[0], in_ready_w[0]});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int m;
        logic [127:0] res;
        do_reset();
        out_ready = 1'b1;
        set_ops(RFC_IN);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_ops(ONES_IN);
        n = 0;
        while (!out_valid_w[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        res = {a_w[0], b_w[0], c_w[0], d_w[0]};
        vectors++;
        if (n != 4 || res !== RFC_OUT || in_ready_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first got %0d edges %h rdy=%b want 4 edges %h rdy=1", n, res,
                     in_ready_w[0], RFC_OUT);
        end
        @(posedge clk); #1;
        m = 1;
        vectors++;
        if (busy_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_bubble got busy=%b vld=%b want busy=1 vld=0", busy_w[0],
                     out_valid_w[0]);
        end
        while (!out_valid_w[0] && m < 10) begin
            @(posedge clk); #1;
            m++;
        end
        in_valid = 1'b0;
        res = {a_w[0], b_w[0], c_w[0], d_w[0]};
        vectors++;
        if (m != 5 || res !== ONES_OUT) begin
            miscompares++;
            $display("FAIL b2b_second got %0d edges %h want 5 edges %h", m, res, ONES_OUT);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] res;
        do_reset();
        set_ops(RFC_IN);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        res = {a_w[0], b_w[0], c_w[0], d_w[0]};
        vectors++;
        if ({out_valid_w[0], busy_w[0], in_ready_w[0]} !== 3'b001 || res !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_mid_abort got vld/busy/rdy=%b out=%h want 001 out=0",
                     {out_valid_w[0], busy_w[0], in_ready_w[0]}, res);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_w[0] && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        res = {a_w[0], b_w[0], c_w[0], d_w[0]};
        vectors++;
        if (n != 4 || res !== RFC_OUT) begin
            miscompares++;
            $display("FAIL reset_mid_rerun got %0d edges %h want 4 edges %h", n, res, RFC_OUT);
        end
    endtask

    task automatic test_wrap();
        logic [127:0] res;
        do_reset();
        set_ops(ONES_IN);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            res = {a_w[k], b_w[k], c_w[k], d_w[k]};
            vectors++;
            if (res !== ONES_OUT || out_valid_w[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_all_ones inst=%0d got %h vld=%b want %h vld=1", k, res,
                         out_valid_w[k], ONES_OUT);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_ops(128'd0);
        test_reset();
        test_rfc_unroll();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
